tdm_demux: RTL and testbench

- Receive end of a time-division-multiplexed link; the transmit end is a 2:1/N:1 mux stepping its select through channels one slot per beat.
- Samples one CH_W-bit slot per valid beat, aligns to frame_sync, and rebuilds NUM_CH parallel channels.
- Publishes all channels atomically once per complete frame.
- Sits between the serial TDM wire and the parallel consumer logic.

---
 rtl/tdm_demux_pkg.sv | 20 ++
 rtl/tdm_slot_counter.sv | 43 ++++
 rtl/tdm_demux.sv | 126 ++++++++++++
 tb/tb_tdm_demux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM receive path and its slot counter.
// TDM_DEMUX_PARITY_EN adds one trailing parity slot per frame.
package tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    function automatic int slot_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

`ifdef TDM_DEMUX_PARITY_EN
    localparam int PARITY_SLOTS = 1;
`else
    localparam int PARITY_SLOTS = 0;
`endif

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index within a TDM frame: clear > load1 > inc; last flags slot NUM_SLOTS-1.
// Registered count, combinational last; never steps past the last slot.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int CNT_W     = slot_w(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last  = (count_q == CNT_W'(NUM_SLOTS - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load1) begin
            count_d = CNT_W'(1);
        end else if (inc && !last) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: aligns on frame_sync, rebuilds NUM_CH channels, publishes a frame the cycle after its last slot.
// valid=0 stalls any length; TDM_DEMUX_PARITY_EN appends a checked parity slot and the parity_err output.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CH_W-1:0]        data_in,
    input  logic                   data_in_valid,
    input  logic                   frame_sync,
    output logic [NUM_CH*CH_W-1:0] ch_out,
    output logic                   frame_valid,
    output logic                   busy,
    output logic                   sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int TOTAL = NUM_CH + PARITY_SLOTS;
    localparam int CNT_W = slot_w(TOTAL);
    localparam int DW    = NUM_CH * CH_W;

    state_t           state_q, state_d;
    logic [DW-1:0]    shadow_q, shadow_d;
    logic [DW-1:0]    ch_out_q, ch_out_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;
    logic             parity_err_q, parity_err_d;
    logic             cnt_clear, cnt_load1, cnt_inc;
    logic [CNT_W-1:0] slot;
    logic             slot_last;

    tdm_slot_counter #(
        .NUM_SLOTS (TOTAL),
        .CNT_W     (CNT_W)
    ) u_slot_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .count (slot),
        .last  (slot_last)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        ch_out_d      = ch_out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        parity_err_d  = 1'b0;
        cnt_clear     = 1'b0;
        cnt_load1     = 1'b0;
        cnt_inc       = 1'b0;

        if (data_in_valid) begin
            if (frame_sync) begin
                // A sync inside RECV is early: drop the partial frame and restart at slot 0.
                sync_err_d          = (state_q == RECV);
                shadow_d            = '0;
                shadow_d[0 +: CH_W] = data_in;
                cnt_load1           = 1'b1;
                state_d             = RECV;
            end else if (state_q == IDLE) begin
                sync_err_d = 1'b1;
            end else begin
                if ({1'b0, slot} < (CNT_W + 1)'(NUM_CH)) begin
                    shadow_d[int'(slot) * CH_W +: CH_W] = data_in;
                end
                if (slot_last) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
`ifdef TDM_DEMUX_PARITY_EN
                    if (data_in[0] == ^shadow_q) begin
                        ch_out_d      = shadow_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
`else
                    ch_out_d      = shadow_d;
                    frame_valid_d = 1'b1;
`endif
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            ch_out_q      <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            ch_out_q      <= ch_out_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign ch_out      = ch_out_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign busy        = (state_q == RECV);
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames with literal expectations plus randomized beats against a frame-list model.
module tb_tdm_demux;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 1;
    localparam int DW     = NUM_CH * CH_W;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int TOTAL  = NUM_CH + 1;
`else
    localparam int TOTAL  = NUM_CH;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [CH_W-1:0] data_in = '0;
    logic            data_in_valid = 1'b0;
    logic            frame_sync = 1'b0;
    logic [DW-1:0]   ch_out;
    logic            frame_valid;
    logic            busy;
    logic            sync_err;
    logic            parity_err_w;

    tdm_demux #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .frame_sync    (frame_sync),
        .ch_out        (ch_out),
        .frame_valid   (frame_valid),
        .busy          (busy),
        .sync_err      (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .parity_err    (parity_err_w)
`endif
    );
`ifndef TDM_DEMUX_PARITY_EN
    assign parity_err_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the current frame is a list of received slots.
    logic [CH_W-1:0] cur [0:16];
    int              cur_len = 0;
    logic [DW-1:0]   exp_ch = '0;
    logic            exp_fv = 1'b0;
    logic            exp_err = 1'b0;
    logic            exp_perr = 1'b0;
    logic            exp_busy = 1'b0;
    bit              started = 1'b0;
    int              frames_seen = 0;

    always @(posedge clk) begin
        logic [DW-1:0] cand;
        exp_fv   = 1'b0;
        exp_err  = 1'b0;
        exp_perr = 1'b0;
        if (reset) begin
            started = 1'b1;
            exp_ch  = '0;
            cur_len = 0;
        end else if (data_in_valid) begin
            if (frame_sync) begin
                if (cur_len > 0) exp_err = 1'b1;
                cur[0]  = data_in;
                cur_len = 1;
            end else if (cur_len == 0) begin
                exp_err = 1'b1;
            end else begin
                cur[cur_len] = data_in;
                cur_len++;
                if (cur_len == TOTAL) begin
                    cand = '0;
                    for (int k = 0; k < NUM_CH; k++) cand[k*CH_W +: CH_W] = cur[k];
`ifdef TDM_DEMUX_PARITY_EN
                    if ((^cand) == cur[NUM_CH][0]) begin
                        exp_ch = cand;
                        exp_fv = 1'b1;
                    end else begin
                        exp_perr = 1'b1;
                    end
`else
                    exp_ch = cand;
                    exp_fv = 1'b1;
`endif
                    if (exp_fv) frames_seen++;
                    cur_len = 0;
                end
            end
        end
        exp_busy = (cur_len > 0);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ch_out", 64'(ch_out), 64'(exp_ch));
            chk("frame_valid", 64'(frame_valid), 64'(exp_fv));
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("sync_err", 64'(sync_err), 64'(exp_err));
            chk("parity_err", 64'(parity_err_w), 64'(exp_perr));
        end
    end

    task automatic beat(input logic v, input logic s, input logic [CH_W-1:0] d);
        data_in_valid = v;
        frame_sync    = s;
        data_in       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        data_in_valid = 1'b0;
        frame_sync    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_ch_out", 64'(ch_out), 64'h0);
        chk("rst_frame_valid", 64'(frame_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_sync_err", 64'(sync_err), 64'h0);

`ifndef TDM_DEMUX_PARITY_EN
        // Basic frame 1,0,1,1
        beat(1, 1, 1); chk("basic_busy_mid", 64'(busy), 64'h1);
        beat(1, 0, 0); beat(1, 0, 1); beat(1, 0, 1);
        chk("basic_fv", 64'(frame_valid), 64'h1);
        chk("basic_ch", 64'(ch_out), 64'hd);
        chk("basic_busy", 64'(busy), 64'h0);
        beat(0, 0, 0); chk("basic_fv_once", 64'(frame_valid), 64'h0);

        // Stall between slots 1 and 2
        beat(1, 1, 1); beat(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            beat(0, 0, 0); chk("stall_no_fv", 64'(frame_valid), 64'h0);
        end
        beat(1, 0, 1); beat(1, 0, 1);
        chk("stall_fv", 64'(frame_valid), 64'h1);
        chk("stall_ch", 64'(ch_out), 64'hd);
        beat(0, 0, 0);

        // Early sync
        beat(1, 1, 1); beat(1, 0, 0);
        beat(1, 1, 0); chk("early_err", 64'(sync_err), 64'h1);
        beat(1, 0, 1); chk("early_err_once", 64'(sync_err), 64'h0);
        beat(1, 0, 1); beat(1, 0, 0);
        chk("early_fv", 64'(frame_valid), 64'h1);
        chk("early_ch", 64'(ch_out), 64'h6);
        beat(0, 0, 0);

        // Missing sync, then reset mid-frame
        do_reset();
        for (int i = 0; i < 3; i++) begin
            beat(1, 0, 1); chk("nosync_err", 64'(sync_err), 64'h1);
            chk("nosync_ch", 64'(ch_out), 64'h0);
        end
        beat(1, 1, 1); beat(1, 0, 1);
        do_reset();
        chk("midrst_busy", 64'(busy), 64'h0);
        beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 1);
        chk("midrst_ch", 64'(ch_out), 64'h8);
        chk("midrst_fv", 64'(frame_valid), 64'h1);

        // Back-to-back frames, second sync on the frame_valid cycle
        beat(1, 1, 1); beat(1, 0, 1); beat(1, 0, 1); beat(1, 0, 1);
        chk("b2b_ch1", 64'(ch_out), 64'hf);
        chk("b2b_fv1", 64'(frame_valid), 64'h1);
        beat(1, 1, 0); chk("b2b_no_err", 64'(sync_err), 64'h0);
        beat(1, 0, 0); beat(1, 0, 1); beat(1, 0, 0);
        chk("b2b_ch2", 64'(ch_out), 64'h4);
        chk("b2b_fv2", 64'(frame_valid), 64'h1);
        beat(0, 0, 0);
`else
        beat(1, 1, 1); beat(1, 0, 0); beat(1, 0, 1); beat(1, 0, 1); beat(1, 0, 1);
        chk("par_ok_fv", 64'(frame_valid), 64'h1);
        chk("par_ok_ch", 64'(ch_out), 64'hd);
        beat(1, 1, 0); beat(1, 0, 1); beat(1, 0, 0); beat(1, 0, 0); beat(1, 0, 0);
        chk("par_bad_err", 64'(parity_err_w), 64'h1);
        chk("par_bad_fv", 64'(frame_valid), 64'h0);
        chk("par_bad_ch", 64'(ch_out), 64'hd);
        beat(0, 0, 0);
`endif

        // Randomized beats, syncs biased toward frame starts
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                logic v, s;
                v = ($urandom_range(0, 9) < 7);
                if (cur_len == 0) s = ($urandom_range(0, 3) != 0);
                else              s = ($urandom_range(0, 4 * TOTAL) == 0);
                beat(v, s, CH_W'($urandom));
            end
        end
        beat(0, 0, 0);
        checks++;
        if (frames_seen < 20) begin
            errors++;
            $display("FAIL random_coverage: got %0d frames required at least 20", frames_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
